prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit instruction-memory words.
REQ-002 Parameter ADDR_W, default 6, word-address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 start  input  1  one-cycle pulse; begins a program load.
REQ-006 in_valid  input  1  byte-stream data valid.
REQ-007 in_data  input  8  program byte, little-endian within each word.
REQ-008 in_last  input  1  marks the final byte of the program; qualified by in_valid.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 imem_we  output  1  instruction-memory write strobe.
REQ-011 imem_addr  output  ADDR_W  word address of the write.
REQ-012 imem_wdata  output  32  assembled instruction word.
REQ-013 core_hold  output  1  holds the processor in reset while high.
REQ-014 done  output  1  load complete, level.
REQ-015 err  output  1  load ended on a partial word, level.
REQ-016 word_count  output  ADDR_W+1  number of words written in the current load.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WRITE and DONE.
REQ-018 IDLE: in_ready=0, core_hold=1; start=1 -> LOAD, clearing word_count, byte index, err and done.
REQ-019 LOAD: in_ready=1; a byte SHALL transfer only when in_valid && in_ready.
REQ-020 Byte k (k=0..3) of a word SHALL be placed in bits [8k+7:8k] of the assembly register.
REQ-021 Acceptance of byte 3 -> WRITE on the next cycle; in_ready SHALL be 0 in WRITE.
REQ-022 WRITE: exactly one cycle with imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=assembled word; word_count increments at the end of the cycle.
REQ-023 WRITE exit: -> DONE if in_last accompanied byte 3 or word_count reaches DEPTH; otherwise -> LOAD.
REQ-024 If in_last accompanies byte k<3, the partial word SHALL be discarded (no write), err=1, and the FSM SHALL go to DONE.
REQ-025 DONE: done=1, core_hold=0, in_ready=0; start=1 -> LOAD with core_hold=1 again from the next cycle.
REQ-026 start SHALL be ignored in LOAD and WRITE.
REQ-027 Peak throughput SHALL be one word per 5 cycles (4 byte cycles plus 1 write cycle).
REQ-028 Bytes presented after DEPTH words have been written SHALL not be accepted (in_ready=0).
REQ-029 imem_addr and imem_wdata are don't-care whenever imem_we=0.

Reset
REQ-030 reset=0 SHALL, asynchronously: set state to IDLE, in_ready=0, imem_we=0, core_hold=1, done=0, err=0 and word_count=0, and clear the byte index and the assembly register.
REQ-031 Reset asserted mid-load SHALL abandon the load and perform no further writes.

Structure
REQ-032 The state encoding, DEPTH and ADDR_W defaults SHALL live in the shared processor package.
REQ-033 Byte-to-word assembly SHALL be one sub-module, byte_packer (byte index plus 32-bit shift/insert register).

Verification
REQ-034 Stream bytes 93,02,50,00 with in_last on the last byte -> one write, addr 0, data 0x00500293; done=1, err=0, word_count=1.
REQ-035 Stream 8 bytes, with in_valid toggling every other cycle -> writes at addr 0 and 1 in order; in_ready=0 during each WRITE cycle.
REQ-036 Stream 256 bytes with no in_last -> 64 writes at addr 0..63; DONE after the 64th write; the 257th byte is not accepted.
REQ-037 in_last on the 6th byte -> one write only (addr 0); err=1; done=1; no write to addr 1.
REQ-038 reset=0 after the 2nd byte of word 3 -> immediately imem_we=0, core_hold=1, word_count=0; a following start reloads from addr 0.
REQ-039 start pulse in DONE -> core_hold rises the next cycle; done and err clear; the new load begins at addr 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and memory sizing defaults.
package prog_loader_pkg;

   localparam int DEPTH_DEF  = 64;
   localparam int ADDR_W_DEF = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into a 32-bit word: a 2-bit byte index
// selects which lane of the assembly register the incoming byte lands in.
module byte_packer (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_load,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic [1:0]  o_idx
);

   logic [1:0]  r_idx;
   logic [31:0] r_word;
   logic [3:0]  w_lane_we;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lane_we[gi] = i_load && (r_idx == 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx <= 2'd0;
      end else if (i_clear) begin
         r_idx <= 2'd0;
      end else if (i_load) begin
         r_idx <= r_idx + 2'd1;
      end
   end

   // Lanes of the previous word are left stale; they are always overwritten before the next write.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_word <= 32'd0;
      end else if (i_clear) begin
         r_word <= 32'd0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_lane_we[k]) r_word[8*k +: 8] <= i_byte;
         end
      end
   end

   assign o_word = r_word;
   assign o_idx  = r_idx;

endmodule

// File: rtl/prog_loader.sv
// Streams a byte program into instruction memory one word at a time while
// holding the core in reset; releases the core once the load finishes.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t           r_state;
   state_t           w_state_next;
   logic [ADDR_W:0]  r_word_count;
   logic             r_err;
   logic             r_last;
   logic             w_accept;
   logic             w_byte3;
   logic             w_start_load;
   logic [ADDR_W:0]  w_count_inc;
   logic [31:0]      w_word;
   logic [1:0]       w_idx;

   assign w_accept     = in_valid && in_ready;
   assign w_byte3      = w_accept && (w_idx == 2'd3);
   assign w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_count_inc  = r_word_count + 1'b1;

   byte_packer u_packer (
      .clk     (clk),
      .i_rst_n (reset),
      .i_clear (w_start_load),
      .i_load  (w_accept),
      .i_byte  (in_data),
      .o_word  (w_word),
      .o_idx   (w_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_next = ST_LOAD;
         ST_LOAD: begin
            if (w_byte3)                     w_state_next = ST_WRITE;
            else if (w_accept && in_last)    w_state_next = ST_DONE;
         end
         ST_WRITE: begin
            if (r_last || (w_count_inc == DEPTH_C)) w_state_next = ST_DONE;
            else                                    w_state_next = ST_LOAD;
         end
         ST_DONE:  if (start) w_state_next = ST_LOAD;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      imem_we   = 1'b0;
      core_hold = 1'b1;
      done      = 1'b0;
      case (r_state)
         ST_LOAD:  in_ready  = (r_word_count < DEPTH_C);
         ST_WRITE: imem_we   = 1'b1;
         ST_DONE: begin
            core_hold = 1'b0;
            done      = 1'b1;
         end
         default: ;
      endcase
   end

   // r_last remembers whether the word now being written closed the program.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_word_count <= '0;
         r_err        <= 1'b0;
         r_last       <= 1'b0;
      end else if (w_start_load) begin
         r_word_count <= '0;
         r_err        <= 1'b0;
         r_last       <= 1'b0;
      end else begin
         if (r_state == ST_WRITE)                     r_word_count <= w_count_inc;
         if (w_accept && in_last && (w_idx != 2'd3))  r_err        <= 1'b1;
         if (w_byte3)                                 r_last       <= in_last;
      end
   end

   assign imem_addr  = r_word_count[ADDR_W-1:0];
   assign imem_wdata = w_word;
   assign err        = r_err;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as words are
// streamed and matched against every imem_we cycle seen by the monitor.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_hold;
   logic        done;
   logic        err;
   logic [6:0]  word_count;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc      = 0;

   prog_loader #(.DEPTH(64), .ADDR_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         chk("ready_in_write", {31'd0, in_ready}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_write", {26'd0, imem_addr}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = sb.pop_front();
            $display("write addr=%0d data=0x%08h (exp addr=%0d data=0x%08h)",
                     imem_addr, imem_wdata, e.addr, e.data);
            chk("wr_addr", {26'd0, imem_addr}, {26'd0, e.addr});
            chk("wr_data", imem_wdata, e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      in_last  = last;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_word(input logic [5:0] addr, input logic [31:0] w,
                            input logic last, input bit gap);
      wr_t e;
      e.addr = addr;
      e.data = w;
      sb.push_back(e);
      for (int k = 0; k < 4; k++) begin
         send_byte(w[8*k +: 8], last && (k == 3));
         if (gap) @(negedge clk);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("done_reached", {31'd0, done}, 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_we", {31'd0, imem_we}, 32'd0);
      chk("rst_hold", {31'd0, core_hold}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_count", {25'd0, word_count}, 32'd0);
      chk("rst_sb_empty", sb.size(), 32'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   function automatic logic [31:0] mk_word(input int i);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((i * 4 + k) * 7 + 3);
      return w;
   endfunction

   initial begin
      int c0;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      in_last  = 1'b0;
      @(negedge clk);
      do_reset();

      // Single word, last on byte 3.
      pulse_start();
      chk("load_hold", {31'd0, core_hold}, 32'd1);
      send_word(6'd0, 32'h0050_0293, 1'b1, 1'b0);
      wait_done();
      chk("t1_err", {31'd0, err}, 32'd0);
      chk("t1_count", {25'd0, word_count}, 32'd1);
      chk("t1_hold", {31'd0, core_hold}, 32'd0);
      chk("t1_ready", {31'd0, in_ready}, 32'd0);

      // Restart from DONE, two words with in_valid toggling.
      pulse_start();
      chk("restart_hold", {31'd0, core_hold}, 32'd1);
      chk("restart_done", {31'd0, done}, 32'd0);
      chk("restart_count", {25'd0, word_count}, 32'd0);
      send_word(6'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      send_word(6'd1, 32'h1234_5678, 1'b0, 1'b1);
      chk("t2_count", {25'd0, word_count}, 32'd2);
      pulse_start();
      @(negedge clk);
      chk("start_ignored_count", {25'd0, word_count}, 32'd2);
      chk("start_ignored_done", {31'd0, done}, 32'd0);
      chk("t2_sb_drained", sb.size(), 32'd0);
      do_reset();

      // Fill all 64 words back to back.
      pulse_start();
      c0 = cyc;
      for (int i = 0; i < 64; i++) send_word(6'(i), mk_word(i), 1'b0, 1'b0);
      wait_done();
      chk("throughput", cyc - c0, 32'd320);
      chk("full_count", {25'd0, word_count}, 32'd64);
      chk("full_err", {31'd0, err}, 32'd0);
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("byte257_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      chk("full_count_after", {25'd0, word_count}, 32'd64);
      do_reset();

      // in_last on the 6th byte: partial word discarded.
      pulse_start();
      send_word(6'd0, 32'hCAFE_F00D, 1'b0, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b1);
      wait_done();
      repeat (3) @(negedge clk);
      chk("partial_err", {31'd0, err}, 32'd1);
      chk("partial_count", {25'd0, word_count}, 32'd1);
      do_reset();

      // Reset mid-load, then reload from address 0.
      pulse_start();
      for (int i = 0; i < 3; i++) send_word(6'(i), mk_word(i + 10), 1'b0, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      chk("midload_count", {25'd0, word_count}, 32'd3);
      do_reset();
      pulse_start();
      send_word(6'd0, 32'h0BAD_C0DE, 1'b1, 1'b0);
      wait_done();
      chk("reload_count", {25'd0, word_count}, 32'd1);

      repeat (2) @(negedge clk);
      chk("final_sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
